// File: rtl/sub_mean.sv
// Windowed DC removal: fills one of two ping-pong banks with 2^LOG2_WIN samples,
// then streams the window back out with its floor mean subtracted and saturated.
module sub_mean #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_WIN   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] mean_out,
    output logic [1:0]            dbg_state
);
    localparam int N  = 1 << LOG2_WIN;
    localparam int SW = DATA_WIDTH + LOG2_WIN;
    localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [2][N];
    logic signed [SW-1:0]   sum [2];
    logic [1:0]             full;
    logic                   fill_sel;
    logic                   drn_sel;
    logic [LOG2_WIN-1:0]    wr_idx;
    logic [LOG2_WIN-1:0]    rd_idx;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // the output side has no backpressure, every out_valid cycle is consumed.
    logic                   accept;
    logic signed [SW-1:0]   in_ext;
    logic signed [SW-1:0]   sum_base;
    logic [DATA_WIDTH-1:0]  mean_next;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH-1:0]  diff_sat;

    assign in_ready  = !full[fill_sel];
    assign accept    = in_valid && in_ready;
    assign in_ext    = {{LOG2_WIN{in_data[DATA_WIDTH-1]}}, in_data};
    assign sum_base  = (wr_idx == '0) ? '0 : sum[fill_sel];
    // Dropping the low LOG2_WIN bits is an arithmetic shift: floor toward -inf.
    assign mean_next = sum[drn_sel][SW-1:LOG2_WIN];
    assign rd_data   = mem[drn_sel][rd_idx];
    assign diff      = {rd_data[DATA_WIDTH-1], rd_data} - {mean_out[DATA_WIDTH-1], mean_out};
    assign dbg_state = state;

    always_comb begin
        diff_sat = diff[DATA_WIDTH-1:0];
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
            diff_sat = diff[DATA_WIDTH] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[fill_sel][wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sum[0]    <= '0;
            sum[1]    <= '0;
            full      <= '0;
            fill_sel  <= 1'b0;
            drn_sel   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            mean_out  <= '0;
        end else begin
            if (accept) begin
                sum[fill_sel] <= sum_base + in_ext;
                wr_idx        <= wr_idx + LOG2_WIN'(1);
                if (&wr_idx) begin
                    full[fill_sel] <= 1'b1;
                    fill_sel       <= ~fill_sel;
                end
            end

            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                // IDLE folds the mean load into its exit edge so the first
                // output lands two edges after the window's last sample.
                IDLE, MEAN: begin
                    if (state == MEAN || full[drn_sel]) begin
                        mean_out <= mean_next;
                        rd_idx   <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    out_valid <= 1'b1;
                    out_data  <= diff_sat;
                    rd_idx    <= rd_idx + LOG2_WIN'(1);
                    if (&rd_idx) begin
                        out_last      <= 1'b1;
                        full[drn_sel] <= 1'b0;
                        drn_sel       <= ~drn_sel;
                        state         <= full[~drn_sel] ? MEAN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_mean.sv
// Directed bench for sub_mean: single windows, floor/saturation corners,
// three-window streaming and an asynchronous reset in the middle of a drain.
module tb_sub_mean;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [15:0] mean_out;
    logic [1:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_acc    = 0;
    int l1          = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic        last_q[$];
    int          cyc_q[$];
    logic [15:0] mean_q[$];

    sub_mean #(.DATA_WIDTH(16), .LOG2_WIN(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .mean_out(mean_out), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_q.push_back(out_data);
            last_q.push_back(out_last);
            cyc_q.push_back(cyc);
            mean_q.push_back(mean_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        int b = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout observed=in_ready_low expected=in_ready_high");
        end
        last_acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_outputs(input int n);
        int b = 0;
        while (obs_q.size() < n && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (obs_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL out_timeout observed=%0d expected=%0d", obs_q.size(), n);
        end
    endtask

    // scoreboard: one 16-sample burst against exp_q, timing and mean
    task automatic check_burst(input string tag, input int first_cyc, input logic [15:0] exp_mean);
        logic [15:0] d, e, m;
        logic        l;
        int          c;
        wait_outputs(16);
        for (int k = 0; k < 16; k++) begin
            if (obs_q.size() == 0 || exp_q.size() == 0) break;
            d = obs_q.pop_front();
            e = exp_q.pop_front();
            l = last_q.pop_front();
            c = cyc_q.pop_front();
            m = mean_q.pop_front();
            chk({tag, "_data"}, $signed(d), $signed(e));
            chk({tag, "_last"}, {31'd0, l}, (k == 15) ? 32'sd1 : 32'sd0);
            chk({tag, "_cycle"}, c, first_cyc + k);
            chk({tag, "_mean"}, $signed(m), $signed(exp_mean));
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_mean", $signed(mean_out), 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_state", {30'd0, dbg_state}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // DC window
        for (int i = 0; i < 16; i++) push(16'd100);
        idle();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'd0);
        check_burst("dc", last_acc + 2, 16'd100);

        // ramp 0..15, mean 7
        for (int i = 0; i < 16; i++) push(16'(i));
        idle();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(i - 7));
        check_burst("ramp", last_acc + 2, 16'd7);

        // sum -17 floors to mean -2
        for (int i = 0; i < 15; i++) push(16'hFFFF);
        push(16'hFFFE);
        idle();
        for (int i = 0; i < 15; i++) exp_q.push_back(16'd1);
        exp_q.push_back(16'd0);
        check_burst("neg_floor", last_acc + 2, 16'hFFFE);

        // sum 458737, mean 28671; -32768-28671 clamps to -32768
        for (int i = 0; i < 15; i++) push(16'h7FFF);
        push(16'h8000);
        idle();
        for (int i = 0; i < 15; i++) exp_q.push_back(16'd4096);
        exp_q.push_back(16'h8000);
        check_burst("sat", last_acc + 2, 16'd28671);

        // three windows with in_valid held high
        for (int i = 0; i < 16; i++) push(16'(i));
        l1 = last_acc;
        chk("stream_ready_w1", {31'd0, in_ready}, 1);
        for (int i = 0; i < 16; i++) push(16'(1000 + 2 * i));
        chk("stream_ready_w2", {31'd0, in_ready}, 0);
        for (int i = 0; i < 16; i++) push(16'(2000 + 3 * i));
        chk("stream_ready_w3", {31'd0, in_ready}, 0);
        idle();
        chk("stream_ready_w3_next", {31'd0, in_ready}, 1);
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(i - 7));
        check_burst("stream_w1", l1 + 2, 16'd7);
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(2 * i - 15));
        check_burst("stream_w2", l1 + 2 + 17, 16'd1015);
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(3 * i - 22));
        check_burst("stream_w3", l1 + 2 + 34, 16'd2022);

        // reset while window A drains and window B is half full
        for (int i = 0; i < 16; i++) push(16'(1000 + i));
        for (int i = 0; i < 8; i++) push(16'(500 + i));
        in_valid = 1'b0;
        #2;
        chk("mid_drain_valid", {31'd0, out_valid}, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 0);
        chk("async_rst_out_data", $signed(out_data), 0);
        chk("async_rst_mean", $signed(mean_out), 0);
        chk("async_rst_out_last", {31'd0, out_last}, 0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 1);
        chk("async_rst_state", {30'd0, dbg_state}, 0);
        obs_q.delete();
        last_q.delete();
        cyc_q.delete();
        mean_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) push(16'(5 * i - 30));
        idle();
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(5 * i - 37));
        check_burst("after_rst", last_acc + 2, 16'd7);
        repeat (30) @(negedge clk);
        chk("no_residue", obs_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
